// File: rtl/if_id_fetch_stage_pkg.sv
// Shared definitions for the fetch stage: bubble encoding and the 2-bit
// branch counter with its saturating helpers.
package if_id_fetch_stage_pkg;

   localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_t;

   function automatic ctr_t sat_inc(input ctr_t c);
      return (c == ST) ? ST : ctr_t'(c + 2'b01);
   endfunction

   function automatic ctr_t sat_dec(input ctr_t c);
      return (c == SNT) ? SNT : ctr_t'(c - 2'b01);
   endfunction

endpackage

// File: rtl/if_id_fetch_stage_if.sv
// Fetch-stage bus: EX control/update, instruction memory, and IF/ID outputs.
interface if_id_fetch_stage_if;
   logic        stall_in;
   logic        flush_in;
   logic [31:0] redirect_pc_in;
   logic        upd_valid_in;
   logic [31:0] upd_pc_in;
   logic        upd_taken_in;
   logic [31:0] upd_target_in;
   logic [31:0] imem_addr_out;
   logic [31:0] imem_data_in;
   logic [31:0] PC_out;
   logic [31:0] instr_out;
   logic        prediction_out;
   logic        valid_out;

   modport master (
      output stall_in, flush_in, redirect_pc_in,
      output upd_valid_in, upd_pc_in, upd_taken_in, upd_target_in,
      output imem_data_in,
      input  imem_addr_out, PC_out, instr_out, prediction_out, valid_out
   );

   modport slave (
      input  stall_in, flush_in, redirect_pc_in,
      input  upd_valid_in, upd_pc_in, upd_taken_in, upd_target_in,
      input  imem_data_in,
      output imem_addr_out, PC_out, instr_out, prediction_out, valid_out
   );
endinterface

// File: rtl/if_id_fetch_stage_branch_target_buffer.sv
// Direct-mapped BTB on word addresses. Lookup is combinational and sees the
// state before any same-cycle update.
module branch_target_buffer
   import if_id_fetch_stage_pkg::*;
#(
   parameter int ENTRIES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [29:0] lkp_word,
   output logic        pred,
   output logic [29:0] pred_target,
   input  logic        upd_valid,
   input  logic [29:0] upd_word,
   input  logic        upd_taken,
   input  logic [29:0] upd_target
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   logic [ENTRIES-1:0] valid;
   logic [TAG_W-1:0]   tag    [ENTRIES];
   logic [29:0]        target [ENTRIES];
   ctr_t               ctr    [ENTRIES];

   logic [IDX_W-1:0] lidx, uidx;
   logic [TAG_W-1:0] ltag, utag;
   logic             uhit;

   assign lidx = lkp_word[IDX_W-1:0];
   assign ltag = lkp_word[29:IDX_W];
   assign uidx = upd_word[IDX_W-1:0];
   assign utag = upd_word[29:IDX_W];
   assign uhit = valid[uidx] && (tag[uidx] == utag);

   always_comb begin
      pred        = valid[lidx] && (tag[lidx] == ltag) && ctr[lidx][1];
      pred_target = target[lidx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid[i]  <= 1'b0;
            tag[i]    <= '0;
            target[i] <= '0;
            ctr[i]    <= WNT;
         end
      end else if (upd_valid) begin
         if (uhit) begin
            ctr[uidx] <= upd_taken ? sat_inc(ctr[uidx]) : sat_dec(ctr[uidx]);
            if (upd_taken) target[uidx] <= upd_target;
         end else if (upd_taken) begin
            // a taken miss evicts whatever alias occupies the slot
            valid[uidx]  <= 1'b1;
            tag[uidx]    <= utag;
            target[uidx] <= upd_target;
            ctr[uidx]    <= WT;
         end
      end
   end
endmodule

// File: rtl/if_id_fetch_stage.sv
// Fetch stage: PC register, BTB-predicted next-PC mux and IF/ID register.
module if_id_fetch_stage
   import if_id_fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          BTB_ENTRIES = 16,
   parameter logic [31:0] NOP_INSTR   = BUBBLE_INSTR
) (
   input logic                clk,
   input logic                rst_n,
   if_id_fetch_stage_if.slave bus
);
   logic [29:0] pc, pc_nxt, btb_target;
   logic        pred;
   logic [31:0] pc_q, instr_q;
   logic        pred_q, valid_q;
   logic        unused;

   // PC is kept word-aligned; low address bits of EX inputs carry no meaning
   assign unused = ^{bus.redirect_pc_in[1:0], bus.upd_pc_in[1:0], bus.upd_target_in[1:0]};

   branch_target_buffer #(.ENTRIES(BTB_ENTRIES)) u_btb (
      .clk        (clk),
      .rst_n      (rst_n),
      .lkp_word   (pc),
      .pred       (pred),
      .pred_target(btb_target),
      .upd_valid  (bus.upd_valid_in),
      .upd_word   (bus.upd_pc_in[31:2]),
      .upd_taken  (bus.upd_taken_in),
      .upd_target (bus.upd_target_in[31:2])
   );

   always_comb begin
      pc_nxt = pc + 30'd1;
      if (bus.flush_in)      pc_nxt = bus.redirect_pc_in[31:2];
      else if (bus.stall_in) pc_nxt = pc;
      else if (pred)         pc_nxt = btb_target;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc      <= RESET_PC[31:2];
         pc_q    <= '0;
         instr_q <= NOP_INSTR;
         pred_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         pc <= pc_nxt;
         if (bus.flush_in) begin
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
            pred_q  <= 1'b0;
            valid_q <= 1'b0;
         end else if (!bus.stall_in) begin
            pc_q    <= {pc, 2'b00};
            instr_q <= bus.imem_data_in;
            pred_q  <= pred;
            valid_q <= 1'b1;
         end
      end
   end

   assign bus.imem_addr_out  = {pc, 2'b00};
   assign bus.PC_out         = pc_q;
   assign bus.instr_out      = instr_q;
   assign bus.prediction_out = pred_q;
   assign bus.valid_out      = valid_q;
endmodule
